// File: rtl/field_sampler_pkg.sv
// field_sampler_pkg: Q16.15 constants, sample type and scan FSM states shared by the sampler slice.
package field_sampler_pkg;
    localparam int Q_FRAC = 15;
    typedef logic [31:0] q16_15_t;
    localparam q16_15_t Q_ONE = 32'h0000_8000;
    localparam q16_15_t Q_SAT = 32'h7FFF_FFFF;
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, ACCUM, WRITE, MOVE} fs_state_t;
endpackage

// File: rtl/field_sampler_if.sv
// field_sampler_if: metaball sample bus plus framebuffer write port driven by the sampler.
interface field_sampler_if #(
    parameter int N_BALLS = 3,
    parameter int W_PX = 32,
    parameter int H_PX = 64
);
    localparam int AW = $clog2(W_PX * H_PX);
    logic px_stb;
    logic [31:0] p_x;
    logic [31:0] p_y;
    logic mov_en;
    logic [N_BALLS-1:0] mb_vld;
    logic [N_BALLS-1:0][31:0] mb_out;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic wr_data;
    modport master (output px_stb, p_x, p_y, mov_en, wr_en, wr_addr, wr_data, input mb_vld, mb_out);
    modport slave (input px_stb, p_x, p_y, mov_en, wr_en, wr_addr, wr_data, output mb_vld, mb_out);
endinterface

// File: rtl/field_sampler_q_sat_add.sv
// q_sat_add: unsigned Q16.15 add clamped to Q_SAT; an operand with bit31 set counts as saturated.
module q_sat_add
    import field_sampler_pkg::*;
(
    input  q16_15_t a,
    input  q16_15_t b,
    output q16_15_t s
);
    logic [32:0] raw;
    assign raw = {1'b0, a} + {1'b0, b};
    assign s = (a[31] | b[31] | raw[32] | raw[31]) ? Q_SAT : raw[31:0];
endmodule

// File: rtl/field_sampler.sv
// field_sampler: raster-scan sampler; per pixel strobes all metaballs, sums their contributions,
// thresholds into one framebuffer bit, and pulses mov_en once after the last pixel of a frame.
module field_sampler
    import field_sampler_pkg::*;
#(
    parameter int N_BALLS = 3,
    parameter int W_PX = 32,
    parameter int H_PX = 64,
    parameter q16_15_t THRESH = Q_ONE,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_stb,
    field_sampler_if.master bus,
    output logic busy,
    output logic [1:0] err
);
    localparam int AW = $clog2(W_PX * H_PX);
    localparam int XW = $clog2(W_PX);
    localparam int YW = $clog2(H_PX);
    localparam int IW = N_BALLS > 1 ? $clog2(N_BALLS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    fs_state_t state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [TW-1:0] wcnt;
    logic [IW-1:0] idx;
    q16_15_t sum;
    q16_15_t add_s;
    q16_15_t cap [N_BALLS];
    logic [AW-1:0] addr;
    logic x_last;
    logic last_px;

    q_sat_add u_add (.a(sum), .b(cap[idx]), .s(add_s));

    assign x_last = x == XW'(W_PX - 1);
    assign last_px = x_last && y == YW'(H_PX - 1);
    assign addr = AW'(int'(y) * W_PX + int'(x));
    assign bus.p_x = 32'(x) << Q_FRAC;
    assign bus.p_y = 32'(y) << Q_FRAC;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.px_stb <= 1'b0;
            bus.mov_en <= 1'b0;
            bus.wr_en <= 1'b0;
            bus.wr_data <= 1'b0;
            bus.wr_addr <= '0;
            busy <= 1'b0;
            err <= '0;
            x <= '0;
            y <= '0;
            wcnt <= '0;
            idx <= '0;
            sum <= '0;
            for (int i = 0; i < N_BALLS; i++) cap[i] <= '0;
        end else begin
            if (frame_stb && state != IDLE) err[1] <= 1'b1;
            case (state)
                IDLE: if (frame_stb) begin
                    state <= ISSUE;
                    bus.px_stb <= 1'b1;
                    busy <= 1'b1;
                end
                ISSUE: begin
                    state <= SETTLE;
                    bus.px_stb <= 1'b0;
                    wcnt <= '0;
                end
                SETTLE: begin
                    state <= WAIT;
                    wcnt <= wcnt + 1'b1;
                end
                WAIT: if (&bus.mb_vld) begin
                    for (int i = 0; i < N_BALLS; i++) cap[i] <= bus.mb_out[i];
                    sum <= '0;
                    idx <= '0;
                    state <= ACCUM;
                end else if (wcnt == TW'(TIMEOUT)) begin
                    // a missing ball forces the pixel on rather than stalling the frame
                    err[0] <= 1'b1;
                    sum <= Q_SAT;
                    bus.wr_en <= 1'b1;
                    bus.wr_addr <= addr;
                    bus.wr_data <= Q_SAT >= THRESH;
                    state <= WRITE;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                ACCUM: begin
                    sum <= add_s;
                    idx <= idx + 1'b1;
                    if (idx == IW'(N_BALLS - 1)) begin
                        bus.wr_en <= 1'b1;
                        bus.wr_addr <= addr;
                        bus.wr_data <= add_s >= THRESH;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    bus.wr_en <= 1'b0;
                    if (last_px) begin
                        x <= '0;
                        y <= '0;
                        bus.mov_en <= 1'b1;
                        state <= MOVE;
                    end else begin
                        x <= x_last ? '0 : x + 1'b1;
                        y <= x_last ? y + 1'b1 : y;
                        bus.px_stb <= 1'b1;
                        state <= ISSUE;
                    end
                end
                MOVE: begin
                    bus.mov_en <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_field_sampler.sv
// tb_field_sampler: directed scenarios against field_sampler with a programmable-delay metaball responder.
module tb_field_sampler;
    import field_sampler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_stb = 1'b0;
    logic busy;
    logic [1:0] err;

    field_sampler_if #(.N_BALLS(3), .W_PX(32), .H_PX(64)) bus ();

    field_sampler #(
        .N_BALLS(3), .W_PX(32), .H_PX(64), .THRESH(32'h0000_8000), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .frame_stb(frame_stb), .bus(bus), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int r_dly = 2;
    logic [2:0] r_mask = 3'b111;
    logic [31:0] r_out [3];
    bit r_stale = 1'b0;

    int n_wr, n_on, n_mov, addr_bad, p_bad, gap, t_px;
    bit timed_out;
    logic busy_mov, busy_after;

    // Metaball responder: drops vld on px_stb (or holds stale vld two cycles), raises it r_dly later.
    initial begin
        int cnt, scnt;
        cnt = 0;
        scnt = 0;
        bus.mb_vld = '0;
        bus.mb_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.px_stb) begin
                cnt = r_dly;
                scnt = r_stale ? 2 : 0;
                bus.mb_vld = r_stale ? 3'b111 : 3'b000;
                if (r_stale) for (int i = 0; i < 3; i++) bus.mb_out[i] = 32'h0000_2000;
            end else begin
                if (scnt > 0) begin
                    scnt--;
                    if (scnt == 0) bus.mb_vld = '0;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.mb_vld = r_mask;
                        for (int i = 0; i < 3; i++) bus.mb_out[i] = r_out[i];
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        frame_stb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_resp(input int dly, input logic [2:0] mask, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c, input bit stale);
        r_dly = dly;
        r_mask = mask;
        r_out[0] = a;
        r_out[1] = b;
        r_out[2] = c;
        r_stale = stale;
    endtask

    // Starts a frame and records writes, mov_en and p_x/p_y against the expected raster order.
    task automatic scan(input int stop_px, input int stb_at, input int budget);
        int mov_c;
        bit inj, in_px;
        mov_c = -1;
        inj = 1'b0;
        in_px = 1'b0;
        n_wr = 0; n_on = 0; n_mov = 0; addr_bad = 0; p_bad = 0; gap = -1; t_px = 0;
        busy_mov = 1'b0; busy_after = 1'b1;
        timed_out = 1'b1;
        frame_stb = 1'b1;
        @(posedge clk);
        #1;
        frame_stb = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (bus.px_stb) begin
                in_px = 1'b1;
                t_px = c;
            end
            if (in_px && (bus.p_x !== 32'((n_wr % 32) << 15) || bus.p_y !== 32'((n_wr / 32) << 15)))
                p_bad++;
            if (bus.wr_en) begin
                if (bus.wr_addr !== 11'(n_wr)) addr_bad++;
                n_on += int'(bus.wr_data);
                n_wr++;
                gap = c - t_px;
                in_px = 1'b0;
            end
            if (bus.mov_en) n_mov++;
            if (bus.mov_en && mov_c < 0) begin
                mov_c = c;
                busy_mov = busy;
            end
            if (mov_c >= 0 && c == mov_c + 1) busy_after = busy;
            if ((mov_c >= 0 && c == mov_c + 40) || n_wr == stop_px) begin
                timed_out = 1'b0;
                break;
            end
            frame_stb = stb_at >= 0 && n_wr == stb_at && !inj;
            if (frame_stb) inj = 1'b1;
            @(posedge clk);
            #1;
        end
        frame_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_stb = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        frame_stb = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset.busy got %b want 0", busy); end
        tests++;
        if (err !== 2'b00) begin fails++; $display("FAIL reset.err got %b want 00", err); end
        tests++;
        if ({bus.px_stb, bus.mov_en, bus.wr_en, bus.wr_data} !== 4'b0000) begin
            fails++;
            $display("FAIL reset.strobes got %b want 0000", {bus.px_stb, bus.mov_en, bus.wr_en, bus.wr_data});
        end
        tests++;
        if ({bus.p_x, bus.p_y, bus.wr_addr} !== 75'd0) begin
            fails++;
            $display("FAIL reset.pos got %h/%h/%h want 0", bus.p_x, bus.p_y, bus.wr_addr);
        end
    endtask

    task automatic test_all_on();
        do_reset();
        set_resp(5, 3'b111, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 1'b0);
        scan(-1, -1, 40000);
        tests++;
        if (timed_out) begin fails++; $display("FAIL all_on.done got timeout want mov_en"); end
        tests++;
        if (n_wr !== 2048) begin fails++; $display("FAIL all_on.writes got %0d want 2048", n_wr); end
        tests++;
        if (n_on !== 2048) begin fails++; $display("FAIL all_on.ones got %0d want 2048", n_on); end
        tests++;
        if (addr_bad !== 0) begin fails++; $display("FAIL all_on.addr_order got %0d bad want 0", addr_bad); end
        tests++;
        if (p_bad !== 0) begin fails++; $display("FAIL all_on.pos got %0d bad want 0", p_bad); end
        tests++;
        if (n_mov !== 1) begin fails++; $display("FAIL all_on.mov_en got %0d want 1", n_mov); end
        tests++;
        if ({busy_mov, busy_after} !== 2'b10) begin
            fails++;
            $display("FAIL all_on.busy got %b want 10", {busy_mov, busy_after});
        end
        tests++;
        if (gap !== 9) begin fails++; $display("FAIL all_on.latency got %0d want 9", gap); end
        tests++;
        if (err !== 2'b00) begin fails++; $display("FAIL all_on.err got %b want 00", err); end
    endtask

    task automatic test_all_off();
        do_reset();
        set_resp(2, 3'b111, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 1'b0);
        scan(-1, -1, 30000);
        tests++;
        if (timed_out || n_wr !== 2048) begin
            fails++;
            $display("FAIL all_off.writes got %0d (timeout %b) want 2048", n_wr, timed_out);
        end
        tests++;
        if (n_on !== 0) begin fails++; $display("FAIL all_off.ones got %0d want 0", n_on); end
        tests++;
        if (n_mov !== 1) begin fails++; $display("FAIL all_off.mov_en got %0d want 1", n_mov); end
        tests++;
        if (busy_after !== 1'b0) begin fails++; $display("FAIL all_off.busy_after got %b want 0", busy_after); end
    endtask

    task automatic test_stale_vld();
        do_reset();
        set_resp(10, 3'b111, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 1'b1);
        scan(20, -1, 2000);
        tests++;
        if (timed_out || n_wr !== 20) begin
            fails++;
            $display("FAIL stale.writes got %0d (timeout %b) want 20", n_wr, timed_out);
        end
        tests++;
        if (n_on !== 20) begin fails++; $display("FAIL stale.ones got %0d want 20", n_on); end
        tests++;
        if (p_bad !== 0) begin fails++; $display("FAIL stale.pos got %0d bad want 0", p_bad); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_resp(2, 3'b101, 32'h0, 32'h0, 32'h0, 1'b0);
        scan(2, -1, 2000);
        tests++;
        if (timed_out || n_wr !== 2) begin
            fails++;
            $display("FAIL timeout.writes got %0d (timeout %b) want 2", n_wr, timed_out);
        end
        tests++;
        if (n_on !== 2) begin fails++; $display("FAIL timeout.ones got %0d want 2", n_on); end
        tests++;
        if (err !== 2'b01) begin fails++; $display("FAIL timeout.err got %b want 01", err); end
        tests++;
        if (gap !== 257) begin fails++; $display("FAIL timeout.latency got %0d want 257", gap); end
        tests++;
        if (addr_bad !== 0) begin fails++; $display("FAIL timeout.addr got %0d bad want 0", addr_bad); end
    endtask

    task automatic test_saturate();
        logic [31:0] vec [5][3];
        logic exp_on [5];
        vec = '{'{32'h7000_0000, 32'h7000_0000, 32'h7000_0000},
                '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0004},
                '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
                '{32'h0000_2000, 32'h0000_2000, 32'h0000_3FFF},
                '{32'h0000_2000, 32'h0000_2000, 32'h0000_4000}};
        exp_on = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 5; v++) begin
            do_reset();
            set_resp(2, 3'b111, vec[v][0], vec[v][1], vec[v][2], 1'b0);
            scan(1, -1, 100);
            tests++;
            if (timed_out || n_on !== int'(exp_on[v])) begin
                fails++;
                $display("FAIL sat.vec%0d got %0d (timeout %b) want %0d", v, n_on, timed_out, exp_on[v]);
            end
        end
    endtask

    task automatic test_busy_stb_rst();
        int late_wr, late_mov, late_busy;
        do_reset();
        set_resp(1, 3'b111, 32'h0000_4000, 32'h0000_4000, 32'h0000_4000, 1'b0);
        scan(500, 100, 10000);
        tests++;
        if (timed_out || n_wr !== 500 || addr_bad !== 0) begin
            fails++;
            $display("FAIL busy_stb.writes got %0d bad %0d (timeout %b) want 500 bad 0", n_wr, addr_bad, timed_out);
        end
        tests++;
        if (err !== 2'b10) begin fails++; $display("FAIL busy_stb.err got %b want 10", err); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.px_stb, bus.mov_en, bus.wr_en, bus.wr_data, busy, err} !== 7'd0) begin
            fails++;
            $display("FAIL mid_rst.ctrl got %b want 0", {bus.px_stb, bus.mov_en, bus.wr_en, bus.wr_data, busy, err});
        end
        tests++;
        if ({bus.p_x, bus.p_y, bus.wr_addr} !== 75'd0) begin
            fails++;
            $display("FAIL mid_rst.pos got %h/%h/%h want 0", bus.p_x, bus.p_y, bus.wr_addr);
        end
        rst = 1'b0;
        late_wr = 0;
        late_mov = 0;
        late_busy = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            late_wr += int'(bus.wr_en);
            late_mov += int'(bus.mov_en);
            late_busy += int'(busy);
        end
        tests++;
        if ({late_wr, late_mov, late_busy} !== 96'd0) begin
            fails++;
            $display("FAIL mid_rst.after got wr %0d mov %0d busy %0d want 0", late_wr, late_mov, late_busy);
        end
    endtask

    initial begin
        r_out[0] = '0;
        r_out[1] = '0;
        r_out[2] = '0;
        test_reset();
        test_all_on();
        test_all_off();
        test_stale_vld();
        test_timeout();
        test_saturate();
        test_busy_stb_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
